operand_select_fifo: RTL and testbench
======================================

Name: operand_select_fifo

Overview:
- Parametrised successor to the TD4 ALU-input data selector.
- Decodes a 4-bit opcode into one of NSRC register sources, or forced zero, at WIDTH bits.
- Buffers the selected operands in a DEPTH-entry first-word-fall-through FIFO with a valid/ready handshake.
- Sits between the register file/input port and the ALU adder, so operand fetch decouples from execute when the ALU stalls.

Parameters:
- WIDTH, 4: data width of each source and of y.
- NSRC, 2: number of sources; legal values 2 or 4.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- ZERO_MASK, 4'b1001: opcode bits whose OR forces a zero operand; TD4 decode.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  4  opcode of the instruction being issued.
- srcs  in  NSRC*WIDTH  packed sources; src k = srcs[k*WIDTH +: WIDTH]; src0 = r1, src1 = r2, and so on.
- in_valid  in  1  op/srcs valid this cycle.
- in_ready  out  1  FIFO can accept; equals !full.
- y  out  WIDTH  operand at FIFO head.
- out_valid  out  1  head valid; equals !empty.
- out_ready  in  1  consumer takes head this cycle.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Decode (combinational, input side):
  - zero = |(op & ZERO_MASK).
  - idx = op[1] when NSRC=2; idx = op[2:1] when NSRC=4.
  - sel_data = zero ? 0 : src[idx].
  - With defaults, {op0|op3, op1}: 00 gives r1, 01 gives r2, 1x gives 0. This is bit-identical to the existing TD4 selector.
- Push: push = in_valid & in_ready. sel_data is written at wr_ptr and wr_ptr increments (mod DEPTH). The operand is captured at the push edge; later changes of srcs do not affect it.
- Pop: pop = out_valid & out_ready. rd_ptr increments (mod DEPTH).
- y shows mem[rd_ptr] whenever out_valid=1. y is 0 whenever out_valid=0; y must not show stale data.
- Latency: push into an empty FIFO gives out_valid=1 and y=data on the next cycle (1 cycle). There is no same-cycle bypass.
- Simultaneous push and pop:
  - Neither full nor empty: both occur, count unchanged.
  - Empty: only the push occurs, since out_valid=0.
  - Full: in_ready=0, so only the pop occurs. in_ready rises the cycle after the pop; there is no combinational ready-from-pop path.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. The range is 0..DEPTH.
- Pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer compare.
- Handshake rules:
  - in_ready depends only on registered state.
  - in_valid held low while in_ready=0 is legal.
  - in_valid=1 while in_ready=0 is a stall: no push, no state change.
- Reset, synchronous, takes priority over push and pop in the same cycle:
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, y=0, in_ready=1.
  - Memory contents are don't-care.
  - Reset asserted mid-stream discards all buffered operands. The first push after reset lands at entry 0.
- Out-of-range parameters (NSRC not 2/4, DEPTH not a power of two) must fail elaboration.
- No $write/$display in synthesizable paths. Debug prints live in the bench.

Test Plan:
- Decode sweep (defaults, FIFO drained each step):
  - Stimulus: r1=4'b0001, r2=4'b1111; op=0..15 each pushed then popped.
  - Required y: 0001 for op in {0000, 0100}; 1111 for {0010, 0110}; 0000 for all 12 others.
- Fill/full: out_ready=0, push 5 operands with DEPTH=4.
  - Required: count goes 1, 2, 3, 4, and in_ready=0 after the 4th.
  - The 5th push is ignored; count stays 4.
  - Draining yields the first 4 values in order.
- Simultaneous push+pop with count=2 for 10 cycles:
  - Required: count stays 2 throughout, and the pointers wrap past 3 to 0.
  - Output order equals input order.
- Full plus pop, with in_valid held high:
  - Cycle n: pop only, count goes 4 to 3.
  - Cycle n+1: in_ready=1, push accepted.
- Reset mid-operation: count=3, assert reset for 1 cycle together with in_valid=1 and out_ready=1.
  - Required next cycle: count=0, out_valid=0, y=0, in_ready=1.
  - The next push reads back correctly after 1 cycle.
- NSRC=4, WIDTH=8: srcs={8'hD4, 8'hC3, 8'hB2, 8'hA1}.
  - Required y: op=4'b0110 gives 8'hD4, op=4'b0010 gives 8'hB2, op=4'b0100 gives 8'hC3, op=4'b0111 gives 8'h00.

Source files
------------

// File: rtl/operand_select_fifo.sv
// -----------------------------------------------------------------------------
// operand_select_fifo
//
// Purpose:
//   This block is the operand-fetch stage placed in front of the ALU adder. It
//   decodes a 4-bit opcode into one of NSRC register sources, or into a forced
//   zero, at WIDTH bits. It then buffers the selected operand in a DEPTH-entry
//   first-word-fall-through FIFO. Operand fetch can therefore keep issuing while
//   the ALU is stalled.
//
//   With the default parameters the decode is bit-identical to the TD4 ALU-input
//   data selector, using {op0|op3, op1}:
//     00 -> r1
//     01 -> r2
//     1x -> 0
//
// Parameters:
//   WIDTH     : data width of each source and of y
//   NSRC      : number of register sources (2 or 4)
//   DEPTH     : FIFO entries (power of two, >= 2)
//   ZERO_MASK : opcode bits whose OR forces a zero operand
//
// Ports:
//   clk       in   1                 rising-edge clock
//   reset     in   1                 synchronous active-high reset
//   op        in   4                 opcode of the instruction being issued
//   srcs      in   NSRC*WIDTH        packed sources, src k = srcs[k*WIDTH +: WIDTH]
//   in_valid  in   1                 op/srcs valid this cycle
//   in_ready  out  1                 FIFO can accept (not full)
//   y         out  WIDTH             operand at FIFO head, 0 when empty
//   out_valid out  1                 head valid (not empty)
//   out_ready in   1                 consumer takes the head this cycle
//   count     out  clog2(DEPTH)+1    current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module operand_select_fifo #(
    parameter int           WIDTH     = 4,
    parameter int           NSRC      = 2,
    parameter int           DEPTH     = 4,
    parameter logic [3:0]   ZERO_MASK = 4'b1001
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               op,
    input  logic [NSRC*WIDTH-1:0]    srcs,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    // -------------------------------------------------------------------------
    // Derived widths
    // -------------------------------------------------------------------------
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NSRC == 4) ? 2 : 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // Parameter legality: an unsupported configuration must not elaborate.
    // -------------------------------------------------------------------------
    if (!(NSRC == 2 || NSRC == 4)) begin : g_bad_nsrc
        $error("operand_select_fifo: NSRC must be 2 or 4");
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("operand_select_fifo: DEPTH must be a power of two >= 2");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("operand_select_fifo: WIDTH must be >= 1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // -------------------------------------------------------------------------
    // Decode (input side, combinational)
    // -------------------------------------------------------------------------
    logic             w_zero;
    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_sel_data;

    assign w_zero = |(op & ZERO_MASK);

    // The source index comes from the opcode bits directly above bit 0. For
    // NSRC=2 that is op[1]; for NSRC=4 it is op[2:1].
    assign w_idx = op[IDX_W:1];

    assign w_sel_data = w_zero ? '0 : srcs[int'(w_idx)*WIDTH +: WIDTH];

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full and empty come from the registered count. This makes in_ready a pure
    // function of state: a pop while full frees a slot only on the next cycle.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    assign w_push = in_valid  & ~w_full;
    assign w_pop  = out_ready & ~w_empty;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the memory array is deliberately left out of reset. Its contents are
    // never observable until written, because y is gated by out_valid. Resetting
    // it would only add a reset fan-out to every storage bit.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= w_sel_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments. That way every
    // register samples the pre-edge values of its neighbours, independent of
    // the order of the statements.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign count     = r_count;

    // The head is masked when the FIFO is empty, so stale entries never leak out.
    assign y = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_operand_select_fifo.sv
// -----------------------------------------------------------------------------
// tb_operand_select_fifo
//
// This is a directed bench for operand_select_fifo. The default instance
// (WIDTH=4, NSRC=2, DEPTH=4) exercises decode, fill/full, streaming, full-plus-
// pop and mid-stream reset. A second instance (WIDTH=8, NSRC=4) checks the
// 4-source decode.
//
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_operand_select_fifo;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic [3:0] op;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    operand_select_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .srcs      ({r2, r1}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    // ---------------- 4-source, 8-bit instance ----------------
    logic [3:0]  op4;
    logic [31:0] srcs4;
    logic        in_valid4;
    logic        in_ready4;
    logic [7:0]  y4;
    logic        out_valid4;
    logic        out_ready4;
    logic [2:0]  count4;

    operand_select_fifo #(.WIDTH(8), .NSRC(4), .DEPTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .op        (op4),
        .srcs      (srcs4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .y         (y4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .count     (count4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected TD4 decode with r1=0001, r2=1111, written out by hand.
    function automatic logic [3:0] td4_expect(input logic [3:0] o);
        case (o)
            4'b0000, 4'b0100: td4_expect = 4'b0001;
            4'b0010, 4'b0110: td4_expect = 4'b1111;
            default:          td4_expect = 4'b0000;
        endcase
    endfunction

    logic [3:0] exp_q [$];
    logic [3:0] nxt;

    initial begin
        reset      = 1'b1;
        op         = '0;
        r1         = '0;
        r2         = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        op4        = '0;
        srcs4      = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y",         32'(y),         32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // ---------------- decode sweep ----------------
        r1 = 4'b0001;
        r2 = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            op       = 4'(i);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            r1       = 4'b0110;  // a later source change must not alter the captured operand
            check($sformatf("dec_valid_op%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("dec_y_op%0d", i),     32'(y),         32'(td4_expect(4'(i))));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            r1        = 4'b0001;
            check($sformatf("dec_empty_y_op%0d", i), 32'(y), 32'd0);
        end

        // ---------------- fill / full ----------------
        op = 4'b0000;  // selects r1
        for (int i = 1; i <= 5; i++) begin
            r1       = 4'(i);
            in_valid = 1'b1;
            tick();
            check($sformatf("fill_count_%0d", i), 32'(count), 32'((i > 4) ? 4 : i));
        end
        in_valid = 1'b0;
        check("fill_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_y_%0d", i), 32'(y), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count),     32'd0);

        // ---------------- streaming at count=2 ----------------
        r1 = 4'd10; in_valid = 1'b1; tick();
        r1 = 4'd11; tick();
        exp_q.push_back(4'd10);
        exp_q.push_back(4'd11);
        check("stream_pre_count", 32'(count), 32'd2);
        nxt       = 4'd12;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r1 = nxt;
            check($sformatf("stream_y_%0d", i), 32'(y), 32'(exp_q.pop_front()));
            exp_q.push_back(nxt);
            nxt = nxt + 4'd1;
            tick();
            check($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            check("stream_tail_y", 32'(y), 32'(exp_q.pop_front()));
            tick();
        end
        out_ready = 1'b0;
        check("stream_done_empty", 32'(out_valid), 32'd0);

        // ---------------- full plus pop, in_valid held high ----------------
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            r1 = 4'(i);
            tick();
        end
        r1        = 4'd9;
        out_ready = 1'b1;
        check("fp_full_ready", 32'(in_ready), 32'd0);
        tick();
        check("fp_pop_count", 32'(count),    32'd3);
        check("fp_ready_up",  32'(in_ready), 32'd1);
        check("fp_head",      32'(y),        32'd2);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("fp_push_count", 32'(count),    32'd4);
        check("fp_ready_down", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        check("fp_drain_0", 32'(y), 32'd2); tick();
        check("fp_drain_1", 32'(y), 32'd3); tick();
        check("fp_drain_2", 32'(y), 32'd4); tick();
        check("fp_drain_3", 32'(y), 32'd9); tick();
        out_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        in_valid = 1'b1;
        r1 = 4'd7; tick();
        r1 = 4'd8; tick();
        r1 = 4'd6; tick();
        check("mr_pre_count", 32'(count), 32'd3);
        r1        = 4'hA;
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("mr_count",     32'(count),     32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_y",         32'(y),         32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        r1       = 4'hC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mr_after_valid", 32'(out_valid), 32'd1);
        check("mr_after_y",     32'(y),         32'hC);
        check("mr_after_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---------------- NSRC=4, WIDTH=8 decode ----------------
        srcs4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        begin
            logic [3:0] ops  [4];
            logic [7:0] exps [4];
            ops[0] = 4'b0110; exps[0] = 8'hD4;
            ops[1] = 4'b0010; exps[1] = 8'hB2;
            ops[2] = 4'b0100; exps[2] = 8'hC3;
            ops[3] = 4'b0111; exps[3] = 8'h00;
            for (int i = 0; i < 4; i++) begin
                op4       = ops[i];
                in_valid4 = 1'b1;
                tick();
                in_valid4 = 1'b0;
                check($sformatf("n4_valid_%0d", i), 32'(out_valid4), 32'd1);
                check($sformatf("n4_y_%0d", i),     32'(y4),         32'(exps[i]));
                out_ready4 = 1'b1;
                tick();
                out_ready4 = 1'b0;
            end
        end
        check("n4_empty", 32'(count4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
